// File: rtl/bp_me_stream_rr_arbiter.sv
// bp_me_stream_rr_arbiter: round-robin arbiter that shares one BedRock Stream consumer
// among num_src_p producers. The grant is locked from the header beat through the last
// beat, so beats of different messages never interleave. Outputs are a zero-latency
// combinational mux of the selected source; the only state is the lock and the rr pointer.
//
// Ports:
//   clk_i, reset_i    clock, synchronous active-high reset
//   msg_*_i           per-source header/data/valid/last, flattened (source 0 in the LSBs)
//   msg_ready_and_o   per-source ready; only the selected source sees the consumer ready
//   msg_*_o           selected header/data/valid/last toward the consumer
//   msg_ready_and_i   consumer ready
//   grant_id_o        index of the current or most recent grantee
//   msg_count_o       per-source completed-message counters (32 bits each), present only
//                     when BP_ME_STREAM_RR_ARBITER_PERF_EN is defined
module bp_me_stream_rr_arbiter #(
  parameter int num_src_p      = 2,
  parameter int header_width_p = 16,
  parameter int data_width_p   = 64,
  localparam int unsigned src_id_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_src_p*header_width_p-1:0] msg_header_i,
  input  logic [num_src_p*data_width_p-1:0]   msg_data_i,
  input  logic [num_src_p-1:0]                msg_v_i,
  input  logic [num_src_p-1:0]                msg_last_i,
  output logic [num_src_p-1:0]                msg_ready_and_o,
  output logic [header_width_p-1:0]           msg_header_o,
  output logic [data_width_p-1:0]             msg_data_o,
  output logic                                msg_v_o,
  output logic                                msg_last_o,
  input  logic                                msg_ready_and_i,
`ifdef BP_ME_STREAM_RR_ARBITER_PERF_EN
  output logic [num_src_p*32-1:0]             msg_count_o,
`endif
  output logic [src_id_width_lp-1:0]          grant_id_o
);

  typedef enum logic {e_ready, e_locked} state_e;

  state_e                     state_r;
  logic [src_id_width_lp-1:0] rr_ptr_r;
  logic [src_id_width_lp-1:0] lock_id_r;
  logic [src_id_width_lp-1:0] sel;
  logic                       found;
  logic                       hs;

  // Source selection: locked source only, else first valid at or after rr_ptr_r.
  always_comb begin
    found = 1'b0;
    sel   = lock_id_r;
    if (state_r == e_locked) begin
      found = msg_v_i[lock_id_r];
    end else begin
      // Descending scan so the lowest offset from rr_ptr_r is written last and wins.
      for (int k = num_src_p - 1; k >= 0; k--) begin
        if (msg_v_i[(int'(rr_ptr_r) + k) % num_src_p]) begin
          found = 1'b1;
          sel   = src_id_width_lp'((int'(rr_ptr_r) + k) % num_src_p);
        end
      end
    end
  end

  assign msg_v_o    = found & ~reset_i;
  assign hs         = msg_v_o & msg_ready_and_i;
  assign grant_id_o = reset_i ? '0 : sel;

  // AND-OR output mux and ready steering.
  always_comb begin
    msg_header_o    = '0;
    msg_data_o      = '0;
    msg_last_o      = 1'b0;
    msg_ready_and_o = '0;
    for (int i = 0; i < num_src_p; i++) begin
      if (src_id_width_lp'(i) == sel) begin
        msg_header_o       = msg_header_i[i*header_width_p +: header_width_p];
        msg_data_o         = msg_data_i[i*data_width_p +: data_width_p];
        msg_last_o         = msg_last_i[i];
        msg_ready_and_o[i] = msg_v_o & msg_ready_and_i;
      end
    end
  end

  // Lock / round-robin state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_ready;
      rr_ptr_r  <= '0;
      lock_id_r <= '0;
    end else if (hs) begin
      lock_id_r <= sel;
      if (msg_last_o) begin
        state_r  <= e_ready;
        rr_ptr_r <= (sel == src_id_width_lp'(num_src_p - 1)) ? '0 : sel + src_id_width_lp'(1);
      end else begin
        state_r  <= e_locked;
      end
    end
  end

`ifdef BP_ME_STREAM_RR_ARBITER_PERF_EN
  logic [31:0] count_r [num_src_p];

  // Completed-message counters, wrapping at 2^32.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_src_p; i++) count_r[i] <= '0;
    end else if (hs & msg_last_o) begin
      count_r[sel] <= count_r[sel] + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < num_src_p; i++) msg_count_o[i*32 +: 32] = count_r[i];
  end
`endif

`ifndef SYNTHESIS
  logic [header_width_p-1:0] lock_header_r;
  logic [num_src_p-1:0]      grant_mask;

  assign grant_mask = num_src_p'(1) << sel;

  always_ff @(posedge clk_i) begin
    if (!reset_i && hs) lock_header_r <= msg_header_o;
  end

  // Protocol checks: header stable across a locked message, ready only to the grantee.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_r == e_locked)
        assert (msg_header_i[int'(lock_id_r)*header_width_p +: header_width_p] == lock_header_r)
          else $error("header of locked source changed mid-message");
      assert ((msg_ready_and_o & ~grant_mask) == '0)
        else $error("ready asserted to a non-grantee");
    end
  end
`endif

endmodule

// File: tb/tb_bp_me_stream_rr_arbiter.sv
// Bench for bp_me_stream_rr_arbiter: directed scenarios with literal expectations, then
// protocol-respecting random traffic, all checked every cycle against a message-level model.
module tb_bp_me_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int HW = 16;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [HW-1:0]   hdr [N];
  logic [DW-1:0]   dat [N];
  logic [N-1:0]    v, last;
  logic [N*HW-1:0] hdr_flat;
  logic [N*DW-1:0] dat_flat;
  logic            cons_ready;
  logic [N-1:0]    src_ready;
  logic [HW-1:0]   out_header;
  logic [DW-1:0]   out_data;
  logic            out_v, out_last;
  logic [IW-1:0]   grant_id;
`ifdef BP_ME_STREAM_RR_ARBITER_PERF_EN
  logic [N*32-1:0] msg_count;
`endif

  always_comb begin
    for (int i = 0; i < N; i++) begin
      hdr_flat[i*HW +: HW] = hdr[i];
      dat_flat[i*DW +: DW] = dat[i];
    end
  end

  bp_me_stream_rr_arbiter #(
    .num_src_p(N), .header_width_p(HW), .data_width_p(DW)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .msg_header_i(hdr_flat), .msg_data_i(dat_flat), .msg_v_i(v), .msg_last_i(last),
    .msg_ready_and_o(src_ready),
    .msg_header_o(out_header), .msg_data_o(out_data), .msg_v_o(out_v), .msg_last_o(out_last),
    .msg_ready_and_i(cons_ready),
`ifdef BP_ME_STREAM_RR_ARBITER_PERF_EN
    .msg_count_o(msg_count),
`endif
    .grant_id_o(grant_id)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner of the open message (-1 none), next priority source, most recent grantee.
  int          m_owner, m_ptr, m_last;
  int unsigned m_cnt [N];
  logic [N-1:0] hs_vec;

  // Random source state.
  bit in_msg [N];
  int left   [N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // At the negedge: predict outputs, compare, then advance the model by this cycle's handshake.
  task automatic sample();
    int sel;
    bit ev;
    logic [N-1:0] er;
    int eg;
    @(negedge clk);
    er = '0;
    ev = 1'b0;
    sel = m_last;
    if (!reset) begin
      if (m_owner >= 0) begin
        sel = m_owner;
        ev  = v[sel];
      end else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (!ev && v[idx]) begin
            ev  = 1'b1;
            sel = idx;
          end
        end
      end
      if (ev) er[sel] = cons_ready;
    end
    eg = reset ? 0 : (ev ? sel : m_last);
    chk("out_v", 64'(out_v), 64'(ev));
    chk("src_ready", 64'(src_ready), 64'(er));
    chk("grant_id", 64'(grant_id), 64'(eg));
    if (ev) begin
      chk("out_header", 64'(out_header), 64'(hdr[sel]));
      chk("out_data", 64'(out_data), 64'(dat[sel]));
      chk("out_last", 64'(out_last), 64'(last[sel]));
    end
    hs_vec = er;
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_last  = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (ev && cons_ready) begin
      m_last = sel;
      if (last[sel]) begin
        m_owner = -1;
        m_ptr   = (sel + 1) % N;
        m_cnt[sel]++;
      end else begin
        m_owner = sel;
      end
    end
  endtask

  // Sources obey ready-and: a presented beat holds until accepted; headers change per message.
  task automatic rand_drive();
    for (int i = 0; i < N; i++) begin
      if (v[i] && hs_vec[i]) begin
        left[i]--;
        v[i] = 1'b0;
        if (left[i] == 0) in_msg[i] = 1'b0;
      end
      if (!v[i]) begin
        if (in_msg[i]) begin
          if ($urandom_range(0, 3) != 0) v[i] = 1'b1;
        end else if ($urandom_range(0, 2) == 0) begin
          in_msg[i] = 1'b1;
          left[i]   = int'($urandom_range(1, 4));
          hdr[i]    = HW'($urandom);
          v[i]      = 1'b1;
        end
        if (v[i]) begin
          dat[i]  = DW'($urandom);
          last[i] = (left[i] == 1);
        end
      end
    end
  endtask

  initial begin
    int g2 [5] = '{0, 1, 2, 3, 0};
    m_owner = -1; m_ptr = 0; m_last = 0; hs_vec = '0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; in_msg[i] = 1'b0; left[i] = 0;
      hdr[i] = HW'(32'hA0 + i);
      dat[i] = DW'(i);
    end
    reset = 1'b1; cons_ready = 1'b1; v = '1; last = '1;
    #1;

    // Reset held 3 cycles with every source valid.
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("rst_v", 64'(out_v), 64'd0);
      chk("rst_ready", 64'(src_ready), 64'd0);
      chk("rst_grant", 64'(grant_id), 64'd0);
      tick();
    end
    reset = 1'b0;

    // All valid, single-beat messages: grants rotate 0,1,2,3,0.
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("rr_grant", 64'(grant_id), 64'(g2[c]));
      chk("rr_ready", 64'(src_ready), 64'(4'b1 << g2[c]));
      tick();
    end
    v = '0; last = '0;
    sample();
    chk("idle_v", 64'(out_v), 64'd0);
    tick();

    // src0 4-beat message; src1 waits and is granted right after src0's last beat.
    for (int b = 0; b < 4; b++) begin
      v[0] = 1'b1; last[0] = (b == 3); dat[0] = DW'(32'h300 + b);
      v[1] = (b >= 1); last[1] = 1'b1;
      sample();
      chk("lock_grant", 64'(grant_id), 64'd0);
      chk("lock_ready", 64'(src_ready), 64'b0001);
      chk("lock_data", 64'(out_data), 64'(32'h300 + b));
      tick();
    end
    v[0] = 1'b0;
    sample();
    chk("after_lock_grant", 64'(grant_id), 64'd1);
    chk("after_lock_ready", 64'(src_ready), 64'b0010);
    tick();
    v[1] = 1'b0;

    // src2 locked, bubbles 2 cycles while src3 waits.
    v[2] = 1'b1; last[2] = 1'b0;
    sample();
    chk("bubble_start_grant", 64'(grant_id), 64'd2);
    tick();
    v[2] = 1'b0; v[3] = 1'b1; last[3] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("bubble_v", 64'(out_v), 64'd0);
      chk("bubble_ready", 64'(src_ready), 64'd0);
      chk("bubble_grant", 64'(grant_id), 64'd2);
      tick();
    end
    v[2] = 1'b1; last[2] = 1'b1;
    sample();
    chk("bubble_end_ready", 64'(src_ready), 64'b0100);
    tick();
    v[2] = 1'b0;
    sample();
    chk("bubble_next_grant", 64'(grant_id), 64'd3);
    tick();
    v[3] = 1'b0;

    // Consumer stalls 5 cycles on src0's last beat; pointer advances only on acceptance.
    v[0] = 1'b1; last[0] = 1'b0;
    sample();
    chk("stall_first_grant", 64'(grant_id), 64'd0);
    tick();
    last[0] = 1'b1; v[1] = 1'b1; last[1] = 1'b1; cons_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("stall_grant", 64'(grant_id), 64'd0);
      chk("stall_v", 64'(out_v), 64'd1);
      chk("stall_ready", 64'(src_ready), 64'd0);
      tick();
    end
    cons_ready = 1'b1;
    sample();
    chk("stall_release_ready", 64'(src_ready), 64'b0001);
    tick();
    sample();
    chk("ptr_advance_grant", 64'(grant_id), 64'd1);
    tick();
    v = '0; last = '0;
    sample();
    tick();

    // Random traffic with consumer backpressure and one mid-run reset.
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        reset = 1'b1;
        v = '0;
        for (int i = 0; i < N; i++) in_msg[i] = 1'b0;
        hs_vec = '0;
      end
      if (c == 2003) reset = 1'b0;
      rand_drive();
      cons_ready = ($urandom_range(0, 3) != 0);
      sample();
      tick();
    end

`ifdef BP_ME_STREAM_RR_ARBITER_PERF_EN
    #1;
    for (int i = 0; i < N; i++) chk("perf_count", 64'(msg_count[i*32 +: 32]), 64'(m_cnt[i]));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
